// File: rtl/frog_pkg.sv
// Shared state encoding and default game constants for the frog movement controller.
package frog_pkg;
    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        RESPAWN  = 2'd1,
        GAMEOVER = 2'd2
    } state_t;

    localparam int ROWS        = 8;
    localparam int COLS        = 8;
    localparam int START_COL   = 3;
    localparam int COOLDOWN    = 4;
    localparam int RESPAWN_CYC = 16;
    localparam int LIVES       = 3;
endpackage

// File: rtl/frog_move_ctrl_key_edge.sv
// Per-key level register with rising-edge detect against the registered copy.
module key_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_edge
);
    logic r_key;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_key <= 1'b0;
        else       r_key <= i_key;
    end

    assign o_edge = i_key & ~r_key;
endmodule

// File: rtl/frog_move_ctrl.sv
// Frog movement controller: key arbitration with cooldown, grid bounds,
// win/crash handling and the PLAY/RESPAWN/GAMEOVER life cycle.
module frog_move_ctrl #(
    parameter int ROWS        = frog_pkg::ROWS,
    parameter int COLS        = frog_pkg::COLS,
    parameter int START_COL   = frog_pkg::START_COL,
    parameter int COOLDOWN    = frog_pkg::COOLDOWN,
    parameter int RESPAWN_CYC = frog_pkg::RESPAWN_CYC,
    parameter int LIVES       = frog_pkg::LIVES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       U,
    input  logic       D,
    input  logic       crash,
    output logic       mvL,
    output logic       mvR,
    output logic       mvU,
    output logic       mvD,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       restart,
    output logic       win,
    output logic [1:0] lives,
    output logic [3:0] score,
    output logic       gameOver
);
    import frog_pkg::*;

    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int RW  = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
    localparam logic [2:0]     ROW_TOP   = 3'(ROWS - 1);
    localparam logic [2:0]     ROW_WIN   = 3'(ROWS - 2);
    localparam logic [2:0]     COL_TOP   = 3'(COLS - 1);
    localparam logic [2:0]     COL_START = 3'(START_COL);
    localparam logic [CDW-1:0] CD_LOAD   = CDW'(COOLDOWN);
    localparam logic [RW-1:0]  RESP_LOAD = RW'(RESPAWN_CYC - 1);

    logic w_eu, w_ed, w_el, w_er;
    logic w_go_u, w_go_d, w_go_l, w_go_r;

    state_t         r_state;
    logic [CDW-1:0] r_cd;
    logic [RW-1:0]  r_resp;
    logic [2:0]     r_row, r_col;
    logic [1:0]     r_lives;
    logic [3:0]     r_score;
    logic           r_mvu, r_mvd, r_mvl, r_mvr, r_restart, r_win, r_gameover;

    key_edge u_key_u (.i_clk(clock), .i_rst(reset), .i_key(U), .o_edge(w_eu));
    key_edge u_key_d (.i_clk(clock), .i_rst(reset), .i_key(D), .o_edge(w_ed));
    key_edge u_key_l (.i_clk(clock), .i_rst(reset), .i_key(L), .o_edge(w_el));
    key_edge u_key_r (.i_clk(clock), .i_rst(reset), .i_key(R), .o_edge(w_er));

    // Highest-priority edge wins the cycle; if it points off-grid nothing is granted.
    always_comb begin
        w_go_u = 1'b0;
        w_go_d = 1'b0;
        w_go_l = 1'b0;
        w_go_r = 1'b0;
        if (r_cd == '0) begin
            if (w_eu)      w_go_u = (r_row != ROW_TOP);
            else if (w_ed) w_go_d = (r_row != 3'd0);
            else if (w_el) w_go_l = (r_col != 3'd0);
            else if (w_er) w_go_r = (r_col != COL_TOP);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= PLAY;
            r_cd       <= '0;
            r_resp     <= '0;
            r_row      <= 3'd0;
            r_col      <= COL_START;
            r_lives    <= 2'(LIVES);
            r_score    <= 4'd0;
            r_mvu      <= 1'b0;
            r_mvd      <= 1'b0;
            r_mvl      <= 1'b0;
            r_mvr      <= 1'b0;
            r_restart  <= 1'b0;
            r_win      <= 1'b0;
            r_gameover <= 1'b0;
        end else begin
            r_mvu     <= 1'b0;
            r_mvd     <= 1'b0;
            r_mvl     <= 1'b0;
            r_mvr     <= 1'b0;
            r_restart <= 1'b0;
            r_win     <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (crash) begin
                        r_restart <= 1'b1;
                        r_row     <= 3'd0;
                        r_col     <= COL_START;
                        r_cd      <= '0;
                        r_lives   <= r_lives - 2'd1;
                        if (r_lives > 2'd1) begin
                            r_state <= RESPAWN;
                            r_resp  <= RESP_LOAD;
                        end else begin
                            r_state    <= GAMEOVER;
                            r_gameover <= 1'b1;
                        end
                    end else begin
                        if (r_cd != '0) r_cd <= r_cd - 1'b1;
                        if (w_go_u && r_row == ROW_WIN) begin
                            r_mvu     <= 1'b1;
                            r_win     <= 1'b1;
                            r_restart <= 1'b1;
                            r_row     <= 3'd0;
                            r_col     <= COL_START;
                            r_cd      <= '0;
                            if (r_score != 4'hF) r_score <= r_score + 4'd1;
                        end else if (w_go_u) begin
                            r_mvu <= 1'b1;
                            r_row <= r_row + 3'd1;
                            r_cd  <= CD_LOAD;
                        end else if (w_go_d) begin
                            r_mvd <= 1'b1;
                            r_row <= r_row - 3'd1;
                            r_cd  <= CD_LOAD;
                        end else if (w_go_l) begin
                            r_mvl <= 1'b1;
                            r_col <= r_col - 3'd1;
                            r_cd  <= CD_LOAD;
                        end else if (w_go_r) begin
                            r_mvr <= 1'b1;
                            r_col <= r_col + 3'd1;
                            r_cd  <= CD_LOAD;
                        end
                    end
                end
                RESPAWN: begin
                    if (r_resp == '0) r_state <= PLAY;
                    else              r_resp  <= r_resp - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mvU      = r_mvu;
    assign mvD      = r_mvd;
    assign mvL      = r_mvl;
    assign mvR      = r_mvr;
    assign row      = r_row;
    assign col      = r_col;
    assign restart  = r_restart;
    assign win      = r_win;
    assign lives    = r_lives;
    assign score    = r_score;
    assign gameOver = r_gameover;
endmodule
